// File: rtl/vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_sequencer
// Brief    : Splits one vector memory op (VLDW/VLDH/VSTW/VSTB) into one
//            scalar data-memory beat per lane. Stalls the pipeline while
//            beats are in flight and assembles the load lanes.
//            Optional: define VSEQ_TIMEOUT_EN to abort an op when a beat
//            waits TIMEOUT_CYC cycles (err pulse, no VRF write).
// Revision : 1.0 - initial release
// ============================================================================
module vec_mem_sequencer #(
  parameter int LANES       = 4,
  parameter int LANE_W      = 16,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      is_store_i,
  input  logic                      narrow_i,
  input  logic [ADDR_W-1:0]         base_addr_i,
  input  logic [LANES*LANE_W-1:0]   store_vec_i,
  output logic                      stall_o,
  output logic                      busy_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [1:0]                mem_size_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i,
  input  logic                      mem_ready_i,
  output logic [LANES*LANE_W-1:0]   load_vec_o,
  output logic                      vrf_we_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int LW = $clog2(LANES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [LW-1:0]           lane_q;
  logic                    is_store_q;
  logic                    narrow_q;
  logic [ADDR_W-1:0]       base_q;
  logic [LANES*LANE_W-1:0] store_q;
  logic [LANES*LANE_W-1:0] load_vec_q;

  logic              w_accept;
  logic              w_beat_done;
  logic              w_last;
  logic              w_timeout;
  logic              w_to_flag;
  logic [ADDR_W-1:0] w_lane_ext;
  logic [ADDR_W-1:0] w_addr;
  logic [LANE_W-1:0] w_store_lane;
  logic [31:0]       w_wdata;
  logic [LANE_W-1:0] w_load_lane;
  logic              w_unused_ok;

  assign w_accept     = start_i && (state_q == S_IDLE);
  assign w_beat_done  = (state_q == S_ACCESS) && mem_ready_i;
  assign w_last       = (lane_q == LW'(LANES - 1));
  assign w_lane_ext   = ADDR_W'(lane_q);
  // Stride is 1 for narrow elements and 4 for words; the sum wraps mod 2^ADDR_W.
  assign w_addr       = base_q + (narrow_q ? w_lane_ext : (w_lane_ext << 2));
  assign w_store_lane = store_q[lane_q*LANE_W +: LANE_W];
  assign load_vec_o   = load_vec_q;
  // Upper read-data bits are unused for narrow lanes; fold them here.
  assign w_unused_ok  = &{1'b0, mem_rdata_i, (TIMEOUT_CYC == 0)};

`ifdef VSEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wait_q;
  logic          timeout_q;

  assign w_timeout = (state_q == S_ACCESS) && !mem_ready_i
                     && (wait_q == WW'(TIMEOUT_CYC - 1));
  assign w_to_flag = timeout_q;

  // Per-beat wait counter; restarts whenever a new beat begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else if (w_accept) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == S_ACCESS) begin
      if (mem_ready_i) begin
        wait_q <= '0;
      end else if (w_timeout) begin
        wait_q    <= '0;
        timeout_q <= 1'b1;
      end else begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_to_flag = 1'b0;
`endif

  // Store data: narrow ops send only the low byte of the lane.
  always_comb begin
    w_wdata = '0;
    if (narrow_q) w_wdata[7:0] = w_store_lane[7:0];
    else          w_wdata[LANE_W-1:0] = w_store_lane;
  end

  // Load lane extraction: narrow ops zero-extend the low byte.
  always_comb begin
    w_load_lane = '0;
    if (narrow_q) w_load_lane[7:0] = mem_rdata_i[7:0];
    else          w_load_lane = mem_rdata_i[LANE_W-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_ACCESS;
      S_ACCESS: if ((w_beat_done && w_last) || w_timeout) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Operand capture, lane counter and load assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q     <= '0;
      is_store_q <= 1'b0;
      narrow_q   <= 1'b0;
      base_q     <= '0;
      store_q    <= '0;
      load_vec_q <= '0;
    end else if (w_accept) begin
      lane_q     <= '0;
      is_store_q <= is_store_i;
      narrow_q   <= narrow_i;
      base_q     <= base_addr_i;
      store_q    <= store_vec_i;
      load_vec_q <= '0;
    end else if (w_beat_done) begin
      if (!is_store_q) load_vec_q[lane_q*LANE_W +: LANE_W] <= w_load_lane;
      lane_q <= lane_q + 1'b1;
    end
  end

  // Output decode from the current state.
  always_comb begin
    stall_o     = w_accept;
    busy_o      = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_size_o  = 2'b00;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    vrf_we_o    = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      S_ACCESS: begin
        stall_o     = 1'b1;
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = is_store_q;
        mem_size_o  = narrow_q ? 2'b00 : 2'b10;
        mem_addr_o  = w_addr;
        mem_wdata_o = w_wdata;
      end
      S_DONE: begin
        busy_o   = 1'b1;
        done_o   = 1'b1;
        vrf_we_o = !is_store_q && !w_to_flag;
        err_o    = w_to_flag;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_mem_sequencer
// Brief    : Scoreboard bench for vec_mem_sequencer (LANES=4, LANE_W=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_mem_sequencer;

`ifdef VSEQ_TIMEOUT_EN
  localparam int TO = 5;
`else
  localparam int TO = 255;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, is_store = 1'b0, narrow = 1'b0;
  logic [31:0] base_addr = '0;
  logic [63:0] store_vec = '0;
  logic        stall, busy, mem_req, mem_we, mem_ready = 1'b0;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [63:0] load_vec;
  logic        vrf_we, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  logic [31:0] req_addr_q[$];

  always #5 clk = ~clk;

  assign mem_rdata = 32'hA0 + mem_addr;

  vec_mem_sequencer #(.LANES(4), .LANE_W(16), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start), .is_store_i(is_store), .narrow_i(narrow),
    .base_addr_i(base_addr), .store_vec_i(store_vec), .stall_o(stall), .busy_o(busy),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_size_o(mem_size), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .load_vec_o(load_vec), .vrf_we_o(vrf_we), .done_o(done), .err_o(err)
  );

  // Drives one op and records what the DUT did; comparisons are in the tests.
  task automatic run_op(input logic st, input logic nr, input logic [31:0] base,
                        input logic [63:0] vec, input int wait_lane, input int wait_n,
                        input bit poke, output int done_cyc, output logic vrf_s,
                        output logic err_s, output logic [31:0] stall_mask,
                        output logic [63:0] lv_s);
    int    beat = 0;
    int    waited = 0;
    beat_t b;
    done_cyc = -1; vrf_s = 1'b0; err_s = 1'b0; stall_mask = '0; lv_s = '0;
    obs_q.delete(); req_addr_q.delete();
    @(negedge clk);
    start = 1'b1; is_store = st; narrow = nr; base_addr = base; store_vec = vec;
    mem_ready = 1'b0;
    #1 stall_mask[0] = stall;
    for (int cyc = 1; cyc < 40; cyc++) begin
      @(negedge clk);
      start = poke && (cyc == 2);
      if (poke && cyc == 2) begin
        base_addr = 32'hDEAD_0000; is_store = ~st; store_vec = '1;
      end else begin
        base_addr = base; is_store = st; store_vec = vec;
      end
      mem_ready = !((beat == wait_lane) && (waited < wait_n));
      #1;
      if (cyc < 32) stall_mask[cyc] = stall;
      if (done) begin
        done_cyc = cyc; vrf_s = vrf_we; err_s = err; lv_s = load_vec;
        break;
      end
      if (mem_req) begin
        req_addr_q.push_back(mem_addr);
        if (mem_ready) begin
          b.addr = mem_addr; b.we = mem_we; b.size = mem_size;
          b.wdata = mem_we ? mem_wdata : 32'h0;
          obs_q.push_back(b);
          beat++;
        end else begin
          waited++;
        end
      end
    end
    start = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({stall, busy, mem_req, mem_we, mem_size, mem_addr, mem_wdata, load_vec, vrf_we, done, err} !== '0) begin
      n_fail++; $display("FAIL reset_held: outputs not all zero (busy=%b req=%b lv=%h)", busy, mem_req, load_vec);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if ({stall, busy, mem_req, done, vrf_we, err, load_vec} !== '0) begin
      n_fail++; $display("FAIL reset_release: busy=%b req=%b done=%b lv=%h, want all 0", busy, mem_req, done, load_vec);
    end
  endtask

  task automatic test_vldw();
    int dc; logic v, e; logic [31:0] sm; logic [63:0] lv; beat_t x, o;
    for (int i = 0; i < 4; i++) begin
      x.addr = 32'h100 + 4*i; x.we = 1'b0; x.size = 2'b10; x.wdata = 32'h0; exp_q.push_back(x);
    end
    run_op(1'b0, 1'b0, 32'h100, 64'h0, -1, 0, 1'b0, dc, v, e, sm, lv);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL vldw_beats: got %0d beats, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== x) begin n_fail++; $display("FAIL vldw_beat: got %h, want %h", o, x); end
    end
    exp_q.delete();
    n_tests++; if (dc !== 5) begin n_fail++; $display("FAIL vldw_done_cycle: got %0d, want 5", dc); end
    n_tests++; if (v !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL vldw_vrf_err: got vrf=%b err=%b, want 1/0", v, e); end
    n_tests++; if (lv !== 64'h01AC_01A8_01A4_01A0) begin n_fail++; $display("FAIL vldw_load_vec: got %h, want 01ac01a801a401a0", lv); end
    n_tests++; if (sm[5:0] !== 6'b011111) begin n_fail++; $display("FAIL vldw_stall: got %b, want 011111", sm[5:0]); end
    repeat (3) @(negedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || load_vec !== 64'h01AC_01A8_01A4_01A0) begin
      n_fail++; $display("FAIL vldw_idle_hold: busy=%b lv=%h, want 0/01ac01a801a401a0", busy, load_vec);
    end
  endtask

  task automatic test_vstb();
    int dc; logic v, e; logic [31:0] sm; logic [63:0] lv; beat_t x, o;
    for (int i = 0; i < 4; i++) begin
      x.addr = 32'h20 + i; x.we = 1'b1; x.size = 2'b00; x.wdata = 32'h11 * (i + 1); exp_q.push_back(x);
    end
    run_op(1'b1, 1'b1, 32'h20, 64'h0044_0033_0022_0011, -1, 0, 1'b0, dc, v, e, sm, lv);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL vstb_beats: got %0d beats, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== x) begin n_fail++; $display("FAIL vstb_beat: got %h, want %h", o, x); end
    end
    exp_q.delete();
    n_tests++; if (dc !== 5 || v !== 1'b0) begin n_fail++; $display("FAIL vstb_done: got cyc=%0d vrf=%b, want 5/0", dc, v); end
  endtask

  task automatic test_vldh_wait();
    int dc; logic v, e; logic [31:0] sm; logic [63:0] lv; beat_t x, o; int hold;
    for (int i = 0; i < 4; i++) begin
      x.addr = 32'h40 + i; x.we = 1'b0; x.size = 2'b00; x.wdata = 32'h0; exp_q.push_back(x);
    end
    run_op(1'b0, 1'b1, 32'h40, 64'h0, 2, 3, 1'b0, dc, v, e, sm, lv);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL vldh_beats: got %0d beats, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== x) begin n_fail++; $display("FAIL vldh_beat: got %h, want %h", o, x); end
    end
    exp_q.delete();
    hold = 0;
    foreach (req_addr_q[k]) if (req_addr_q[k] == 32'h42) hold++;
    n_tests++; if (hold != 4) begin n_fail++; $display("FAIL vldh_hold: addr 0x42 seen %0d cycles, want 4", hold); end
    n_tests++; if (dc !== 8) begin n_fail++; $display("FAIL vldh_done_cycle: got %0d, want 8", dc); end
    n_tests++; if (lv !== 64'h00E3_00E2_00E1_00E0) begin n_fail++; $display("FAIL vldh_load_vec: got %h, want 00e300e200e100e0", lv); end
  endtask

  task automatic test_wrap();
    int dc; logic v, e; logic [31:0] sm; logic [63:0] lv; beat_t x, o;
    logic [31:0] addrs [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    logic [15:0] dat [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    for (int i = 0; i < 4; i++) begin
      x.addr = addrs[i]; x.we = 1'b1; x.size = 2'b10; x.wdata = {16'h0, dat[i]}; exp_q.push_back(x);
    end
    run_op(1'b1, 1'b0, 32'hFFFF_FFF8, 64'hDDDD_CCCC_BBBB_AAAA, -1, 0, 1'b0, dc, v, e, sm, lv);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_beats: got %0d beats, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== x) begin n_fail++; $display("FAIL wrap_beat: got %h, want %h", o, x); end
    end
    exp_q.delete();
    n_tests++; if (dc !== 5 || v !== 1'b0) begin n_fail++; $display("FAIL wrap_done: got cyc=%0d vrf=%b, want 5/0", dc, v); end
  endtask

  task automatic test_reset_mid();
    int dc; logic v, e; logic [31:0] sm; logic [63:0] lv; beat_t x, o; bit saw_done;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; narrow = 1'b0; base_addr = 32'h200; mem_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({stall, busy, mem_req, mem_we, mem_size, mem_addr, mem_wdata, load_vec, vrf_we, done, err} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: busy=%b req=%b addr=%h lv=%h, want all 0", busy, mem_req, mem_addr, load_vec);
    end
    saw_done = 1'b0;
    repeat (3) begin @(negedge clk); #1; if (done || vrf_we) saw_done = 1'b1; end
    rst = 1'b0; mem_ready = 1'b0;
    repeat (2) begin @(negedge clk); #1; if (done || vrf_we) saw_done = 1'b1; end
    n_tests++; if (saw_done) begin n_fail++; $display("FAIL midreset_no_done: got done/vrf_we after abort, want none"); end
    for (int i = 0; i < 4; i++) begin
      x.addr = 32'h200 + 4*i; x.we = 1'b0; x.size = 2'b10; x.wdata = 32'h0; exp_q.push_back(x);
    end
    run_op(1'b0, 1'b0, 32'h200, 64'h0, -1, 0, 1'b1, dc, v, e, sm, lv);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fresh_beats: got %0d beats, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      x = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== x) begin n_fail++; $display("FAIL fresh_beat: got %h, want %h", o, x); end
    end
    exp_q.delete();
    n_tests++; if (dc !== 5 || v !== 1'b1) begin n_fail++; $display("FAIL fresh_done: got cyc=%0d vrf=%b, want 5/1", dc, v); end
    n_tests++; if (lv !== 64'h02AC_02A8_02A4_02A0) begin n_fail++; $display("FAIL fresh_load_vec: got %h, want 02ac02a802a402a0", lv); end
  endtask

`ifdef VSEQ_TIMEOUT_EN
  task automatic test_timeout();
    int dc; logic v, e; logic [31:0] sm; logic [63:0] lv;
    run_op(1'b0, 1'b0, 32'h300, 64'h0, 0, 1000, 1'b0, dc, v, e, sm, lv);
    n_tests++; if (dc !== 6) begin n_fail++; $display("FAIL timeout_cycle: got %0d, want 6", dc); end
    n_tests++; if (e !== 1'b1 || v !== 1'b0) begin n_fail++; $display("FAIL timeout_flags: got err=%b vrf=%b, want 1/0", e, v); end
    n_tests++; if (obs_q.size() != 0 || lv !== 64'h0) begin n_fail++; $display("FAIL timeout_data: got %0d beats lv=%h, want 0/0", obs_q.size(), lv); end
    @(negedge clk); #1;
    n_tests++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy=%b err=%b, want 0/0", busy, err); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vldw();
    test_vstb();
    test_vldh_wait();
    test_wrap();
    test_reset_mid();
`ifdef VSEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Multi-cycle sequencer for the vector memory instructions (VLDW, VLDH, VSTW, VSTB).
- The decoder issues one vector memory op; this block breaks it into one scalar data-memory access per lane, holds the pipeline stalled meanwhile, and assembles load lanes for the vector register file write.
- Sits between the decode/execute stage and the data-memory port, in parallel with the scalar load/store path.

Parameters:
- LANES, 4, number of vector lanes (power of two, 2..16).
- LANE_W, 16, bits per vector lane (8..32).
- ADDR_W, 32, data-memory address width.
- TIMEOUT_CYC, 255, max wait cycles per lane beat (used only with VSEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  decoder requests a vector memory op (1-cycle pulse or level).
- is_store  in  1  1 = VSTW/VSTB, 0 = VLDW/VLDH.
- narrow  in  1  0 = word element (stride 4), 1 = narrow element (stride 1, byte access).
- base_addr  in  ADDR_W  address of lane 0.
- store_vec  in  LANES*LANE_W  store source; lane i = bits [i*LANE_W +: LANE_W].
- stall  out  1  freeze the upstream pipeline.
- busy  out  1  sequencer not IDLE.
- mem_req  out  1  memory access valid.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_size  out  2  2'b10 = word, 2'b00 = byte.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data, valid when mem_ready=1.
- mem_ready  in  1  beat accepted/completed this cycle.
- load_vec  out  LANES*LANE_W  assembled load vector, stable from DONE until the next accepted start.
- vrf_we  out  1  vector register file write enable (1 cycle).
- done  out  1  operation-complete pulse (1 cycle).
- err  out  1  timeout abort pulse (0 without VSEQ_TIMEOUT_EN).

Behaviour:
- Reset: async, all state cleared.
  - State = IDLE; lane counter = 0; load_vec = 0.
  - All outputs 0.
  - Reset mid-operation aborts the op immediately; no vrf_we or done is produced.
- FSM states and transitions:
  - IDLE -> ACCESS on start.
  - ACCESS -> ACCESS while beats remain.
  - ACCESS -> DONE when the last lane's beat completes (mem_ready=1 with counter = LANES-1).
  - DONE -> IDLE unconditionally.
- On start in IDLE:
  - Register is_store, narrow, base_addr and store_vec.
  - Clear the lane counter.
- start outside IDLE is ignored. No queueing; the decoder holds the instruction while stall=1.
- stall is combinational: (start && IDLE) || ACCESS. It is low in DONE so the pipeline advances that cycle.
- busy = (state != IDLE).
- ACCESS outputs:
  - mem_req = 1.
  - mem_we = is_store.
  - mem_size = narrow ? 00 : 10.
  - mem_addr = base + i*(narrow?1:4), truncated mod 2^ADDR_W (wrap-around allowed, no flag).
- Stores:
  - Word: mem_wdata = zero-extended lane i.
  - Narrow: mem_wdata = {24'b0, lane i[7:0]}.
- Loads, on each mem_ready:
  - Word: lane i = mem_rdata[LANE_W-1:0].
  - Narrow: lane i = zero-extended mem_rdata[7:0].
- Handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - A beat completes in the cycle mem_ready=1; the counter increments on that edge.
  - mem_ready outside ACCESS is ignored.
- DONE: done = 1; vrf_we = !is_store; mem_req = 0; stall = 0.
- Latency: with mem_ready tied high, start in cycle 0 puts lane i in cycle 1+i and DONE in cycle LANES+1. Each wait cycle on mem_ready adds one cycle.

Optional Feature:
- Macro: VSEQ_TIMEOUT_EN.
- Enabled:
  - A per-beat wait counter resets at each beat start.
  - If mem_ready stays low for TIMEOUT_CYC consecutive ACCESS cycles, go to DONE with err = 1, done = 1, vrf_we = 0.
  - load_vec keeps the lanes completed so far; unfilled lanes are 0.
- Disabled: no counter; err tied 0; the sequencer waits indefinitely.

Test Plan:
- VLDW, LANES=4, base 0x100, mem_ready=1, rdata = 0xA0+addr:
  - addrs 0x100/104/108/10C in cycles 1-4.
  - DONE cycle 5: vrf_we=1, load_vec = {0x01AC,0x01A8,0x01A4,0x01A0}.
  - stall high cycles 0-4.
- VSTB, base 0x20, store_vec = {0x0044,0x0033,0x0022,0x0011}:
  - beats addr 0x20..0x23, mem_size=00, mem_we=1, wdata 0x11,0x22,0x33,0x44.
  - done=1, vrf_we=0.
- VLDH with mem_ready low 3 cycles on lane 2:
  - mem_addr holds base+2 for 4 cycles.
  - DONE arrives in cycle 8.
- Wrap-around: VSTW, base 0xFFFFFFF8 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rst asserted during lane 1 of VLDW:
  - outputs 0 asynchronously; no done.
  - next start runs a fresh op from lane 0.
  - start pulses during busy are ignored.
- With VSEQ_TIMEOUT_EN, TIMEOUT_CYC=5, mem_ready held 0 on lane 0:
  - err=1 and done=1 on cycle 6, vrf_we=0, then IDLE.
